// File: rtl/fractal_pkg.sv
// Shared types and constants for the escape-time datapath: default escape radius squared, iteration width, FSM states.
// Pure declarations; no latency or flow control of its own.
package fractal_pkg;

    localparam int          ITER_W_DEFAULT    = 16;
    localparam logic [63:0] ESCAPE_SQ_DEFAULT = 64'h4010_0000_0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MAG,
        ACK_MAG,
        COMPARE,
        RESULT
    } state_e;

endpackage

// File: rtl/fp_mag_compare.sv
// Magnitude compare of two non-negative doubles: gt = |a| > |b| as raw 63-bit unsigned compare.
// Combinational, zero latency, no flow control; +Inf and NaN encodings order above every finite value.
module fp_mag_compare (
    input  logic [63:0] a_dat,
    input  logic [63:0] b_dat,
    output logic        gt
);

    // Sign bits are deliberately ignored: |z|^2 is never negative, so a set sign is treated as magnitude only.
    logic unused_sign;
    assign unused_sign = a_dat[63] ^ b_dat[63];

    assign gt = a_dat[62:0] > b_dat[62:0];

endmodule

// File: rtl/escape_checker.sv
// Escape-time loop controller: compares each |z|^2 against the threshold and counts iterations (ESCAPE_RADIUS_PROG_EN adds a threshold port).
// 3 cycles mag_done->next_iter/result_valid; mag_done held until mag_ack, result held until result_ack.
module escape_checker
    import fractal_pkg::*;
#(
    parameter int MAX_ITER = 256,
    parameter int ITER_W   = ITER_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mag_done,
    input  logic [63:0]       mag_in,
    output logic              mag_ack,
    output logic              next_iter,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              escaped,
    output logic [ITER_W-1:0] iter_count,
`ifdef ESCAPE_RADIUS_PROG_EN
    input  logic [63:0]       threshold,
`endif
    output logic              busy
);

    localparam logic [ITER_W-1:0] LAST_CHECK = ITER_W'(MAX_ITER - 1);

    state_e            state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [63:0]       mag_q, mag_d;
    logic              esc_q, esc_d;
    logic              next_iter_q, next_iter_d;
    logic [63:0]       thr;
    logic              mag_gt;

`ifdef ESCAPE_RADIUS_PROG_EN
    logic [63:0] thr_q, thr_d;

    // Threshold is frozen per point so upstream may change it while a point is in flight.
    always_comb begin
        thr_d = thr_q;
        if (state_q == IDLE && start) begin
            thr_d = threshold;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_q <= ESCAPE_SQ_DEFAULT;
        end else begin
            thr_q <= thr_d;
        end
    end

    assign thr = thr_q;
`else
    assign thr = ESCAPE_SQ_DEFAULT;
`endif

    fp_mag_compare u_cmp (
        .a_dat (mag_q),
        .b_dat (thr),
        .gt    (mag_gt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        esc_d       = esc_q;
        next_iter_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    esc_d   = 1'b0;
                    state_d = WAIT_MAG;
                end
            end
            WAIT_MAG: begin
                if (mag_done) begin
                    mag_d   = mag_in;
                    state_d = ACK_MAG;
                end
            end
            ACK_MAG: begin
                state_d = COMPARE;
            end
            COMPARE: begin
                if (mag_gt) begin
                    esc_d   = 1'b1;
                    state_d = RESULT;
                end else if (cnt_q == LAST_CHECK) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = RESULT;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    next_iter_d = 1'b1;
                    state_d     = WAIT_MAG;
                end
            end
            RESULT: begin
                if (result_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mag_q       <= '0;
            esc_q       <= 1'b0;
            next_iter_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            esc_q       <= esc_d;
            next_iter_q <= next_iter_d;
        end
    end

    // next_iter is registered so it lands in the same cycle as the return to WAIT_MAG.
    assign mag_ack      = (state_q == ACK_MAG);
    assign result_valid = (state_q == RESULT);
    assign busy         = (state_q != IDLE);
    assign next_iter    = next_iter_q;
    assign escaped      = esc_q;
    assign iter_count   = cnt_q;

endmodule

// File: tb/tb_escape_checker.sv
// Table-driven bench for escape_checker with a scoreboard of per-point expectations, plus reset and RESULT-hold sequences.
module tb_escape_checker;
    import fractal_pkg::*;

    localparam int MI = 4;
    localparam int IW = 16;

    localparam logic [63:0] D_0P0  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] D_1P0  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D_2P0  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D_3P0  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D_4P0  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] D_4UP  = 64'h4010_0000_0000_0001;
    localparam logic [63:0] D_4DN  = 64'h400F_FFFF_FFFF_FFFF;
    localparam logic [63:0] D_5P0  = 64'h4014_0000_0000_0000;
    localparam logic [63:0] D_8P0  = 64'h4020_0000_0000_0000;
    localparam logic [63:0] D_NAN  = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] D_INF  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] D_N4P0 = 64'hC010_0000_0000_0000;
    localparam logic [63:0] D_N8P0 = 64'hC020_0000_0000_0000;

    typedef struct packed {
        logic [3:0][63:0] mag;
        int               n;
        logic             esc;
        int               cnt;
        int               pulses;
    } vec_t;

    typedef struct packed {
        logic esc;
        int   cnt;
        int   pulses;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          mag_done = 1'b0;
    logic          result_ack = 1'b0;
    logic [63:0]   mag_in = '0;
    logic          mag_ack;
    logic          next_iter;
    logic          result_valid;
    logic          escaped;
    logic          busy;
    logic [IW-1:0] iter_count;
`ifdef ESCAPE_RADIUS_PROG_EN
    logic [63:0]   threshold = ESCAPE_SQ_DEFAULT;
`endif

    int   checks = 0;
    int   errors = 0;
    int   ni_cnt = 0;
    int   ack_cnt = 0;
    exp_t sb[$];

    escape_checker #(.MAX_ITER(MI), .ITER_W(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mag_done     (mag_done),
        .mag_in       (mag_in),
        .mag_ack      (mag_ack),
        .next_iter    (next_iter),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .escaped      (escaped),
        .iter_count   (iter_count),
`ifdef ESCAPE_RADIUS_PROG_EN
        .threshold    (threshold),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (next_iter) ni_cnt++;
        if (mag_ack) ack_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] m0, input logic [63:0] m1,
                                input logic [63:0] m2, input logic [63:0] m3,
                                input int n, input logic esc, input int cnt, input int pulses);
        vec_t v;
        v.mag[0] = m0;
        v.mag[1] = m1;
        v.mag[2] = m2;
        v.mag[3] = m3;
        v.n      = n;
        v.esc    = esc;
        v.cnt    = cnt;
        v.pulses = pulses;
        return v;
    endfunction

    // One magnitude handshake; mag_done rises at a negedge, outputs checked on the next three negedges.
    task automatic do_check(input logic [63:0] m, output bit finished);
        mag_in   = m;
        mag_done = 1'b1;
        @(negedge clk);
        chk("mag_ack_cycle1", mag_ack, 1'b1);
        mag_done = 1'b0;
        @(negedge clk);
        chk("quiet_cycle2", {mag_ack, next_iter, result_valid}, 3'b000);
        @(negedge clk);
        chk("latency_cycle3", next_iter | result_valid, 1'b1);
        finished = result_valid;
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk("valid_after_ack", result_valid, 1'b0);
        chk("busy_after_ack", busy, 1'b0);
    endtask

    task automatic drive_point(input vec_t v, input bit do_ack);
        exp_t e;
        bit   done;
        int   ni0;
        sb.push_back('{esc: v.esc, cnt: v.cnt, pulses: v.pulses});
        ni0  = ni_cnt;
        done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < v.n && !done; i++) begin
            do_check(v.mag[i], done);
        end
        e = sb.pop_front();
        chk("result_valid", result_valid, 1'b1);
        chk("escaped", escaped, e.esc);
        chk("iter_count", iter_count, e.cnt);
        chk("next_iter_pulses", ni_cnt - ni0, e.pulses);
        if (do_ack) ack_result();
    endtask

    vec_t vecs[8];

    initial begin
        bit d;
        int ni_snap;
        int ack_snap;

        vecs[0] = mk(D_5P0,  D_0P0,  D_0P0, D_0P0, 1, 1'b1, 0, 0);
        vecs[1] = mk(D_4P0,  D_4P0,  D_4P0, D_4P0, 4, 1'b0, 4, 3);
        vecs[2] = mk(D_1P0,  D_2P0,  D_8P0, D_0P0, 3, 1'b1, 2, 2);
        vecs[3] = mk(D_NAN,  D_0P0,  D_0P0, D_0P0, 1, 1'b1, 0, 0);
        vecs[4] = mk(D_INF,  D_0P0,  D_0P0, D_0P0, 1, 1'b1, 0, 0);
        vecs[5] = mk(D_N4P0, D_N8P0, D_0P0, D_0P0, 2, 1'b1, 1, 1);
        vecs[6] = mk(D_4UP,  D_0P0,  D_0P0, D_0P0, 1, 1'b1, 0, 0);
        vecs[7] = mk(D_4DN,  D_0P0,  D_0P0, D_0P0, 4, 1'b0, 4, 3);

        repeat (3) @(negedge clk);
        chk("reset_outputs", {mag_ack, next_iter, result_valid, escaped, busy}, 5'b0);
        chk("reset_iter_count", iter_count, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // mag_done while IDLE must not be acknowledged
        ack_snap = ack_cnt;
        mag_done = 1'b1;
        mag_in   = D_8P0;
        repeat (3) @(negedge clk);
        mag_done = 1'b0;
        chk("idle_mag_done_ignored", ack_cnt - ack_snap, 0);
        chk("idle_still", busy, 1'b0);

        for (int k = 0; k < 8; k++) begin
            drive_point(vecs[k], 1'b1);
        end

        // Reset in WAIT_MAG after two iterations, asserted between clock edges
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_check(D_1P0, d);
        do_check(D_1P0, d);
        chk("pre_reset_count", iter_count, 2);
        chk("pre_reset_busy", busy, 1'b1);
        mag_in   = D_8P0;
        mag_done = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", {mag_ack, next_iter, result_valid, escaped, busy}, 5'b0);
        chk("async_reset_count", iter_count, 0);
        @(negedge clk);
        reset = 1'b1;
        ni_snap  = ni_cnt;
        ack_snap = ack_cnt;
        repeat (5) @(negedge clk);
        chk("post_reset_no_ack", ack_cnt - ack_snap, 0);
        chk("post_reset_no_next_iter", ni_cnt - ni_snap, 0);
        chk("post_reset_idle", busy, 1'b0);
        mag_done = 1'b0;

        // Result held without ack; start, mag_done and a fresh mag_in are ignored in RESULT
        drive_point(mk(D_5P0, D_0P0, D_0P0, D_0P0, 1, 1'b1, 0, 0), 1'b0);
        ack_snap = ack_cnt;
        start    = 1'b1;
        mag_done = 1'b1;
        mag_in   = D_0P0;
        repeat (4) @(negedge clk);
        start    = 1'b0;
        mag_done = 1'b0;
        chk("held_valid", result_valid, 1'b1);
        chk("held_escaped", escaped, 1'b1);
        chk("held_count", iter_count, 0);
        chk("held_no_ack", ack_cnt - ack_snap, 0);
        ack_result();

`ifdef ESCAPE_RADIUS_PROG_EN
        threshold = D_2P0;
        drive_point(mk(D_3P0, D_0P0, D_0P0, D_0P0, 1, 1'b1, 0, 0), 1'b1);
        threshold = ESCAPE_SQ_DEFAULT;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
